// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
package ring_arb_pkg;

    localparam int RING_N_MAX = 16;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    function automatic logic [3:0] next_idx(input logic [3:0] idx, input int n);
        if (int'(idx) >= n - 1)
            return 4'd0;
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface ring_rr_arbiter_if #(
    parameter int N  = 16,
    parameter int IW = 4
);
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic          timeout;

    modport master (
        output req,
        input  grant, grant_idx, busy, timeout
    );

    modport slave (
        input  req,
        output grant, grant_idx, busy, timeout
    );
endinterface

// File: rtl/ring_rr_arbiter_decode.sv
// Index to one-hot decoder; out-of-range indices decode to all ones.
module ring_decode #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    always_comb begin
        onehot = '1;
        if (int'(idx) < N) begin
            onehot      = '0;
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with rotating pointer and one dead cycle between owners.
// Optional owner revocation after HOLD_MAX cycles: define RING_ARB_TIMEOUT_EN.
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = 16,
    parameter int IW       = $clog2(N),
    parameter int HOLD_MAX = 8
) (
    input logic               clk,
    input logic               nRST,
    ring_rr_arbiter_if.slave  bus
);

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          busy_q, busy_d;
    logic          release_c;
    logic          take;

    logic [N-1:0]   elig;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;
    logic [IW-1:0]  sel;
    logic           found;
    logic [N-1:0]   sel_oh;

`ifdef RING_ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  blk_q, blk_d;
    logic          to_q, to_d;
    logic          revoke;

    // A revoked owner stays out of arbitration until it drops its request.
    assign elig   = bus.req & ~blk_q;
    assign revoke = (state_q == GRANT) && bus.req[idx_q]
                    && (hold_q == HW'(HOLD_MAX));
`else
    logic revoke;

    assign elig   = bus.req;
    assign revoke = 1'b0;
`endif

    // Rotate so the pointer lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        shifted = {elig, elig} >> ptr_q;
        rot     = shifted[N-1:0];
        off     = '0;
        found   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = IW'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, off} + {1'b0, ptr_q};
        if (int'(sum) >= N)
            sum = sum - (IW + 1)'(N);
        sel = sum[IW-1:0];
    end

    ring_decode #(
        .N  (N),
        .IW (IW)
    ) u_decode (
        .idx    (sel),
        .onehot (sel_oh)
    );

    assign release_c = !bus.req[idx_q] || revoke;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                // GAP is the dead cycle itself, so it may arbitrate for the next edge.
                if (found) begin
                    take    = 1'b1;
                    state_d = GRANT;
                    idx_d   = sel;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_d = GAP;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    ptr_d   = IW'(next_idx(4'(idx_q), N));
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = busy_d ? (take ? sel_oh : grant_q) : '0;
    end

`ifdef RING_ARB_TIMEOUT_EN
    always_comb begin
        hold_d = hold_q;
        blk_d  = blk_q & bus.req;
        to_d   = 1'b0;
        if (take) begin
            hold_d = HW'(1);
        end else if (state_q == GRANT) begin
            if (release_c) begin
                hold_d = '0;
                if (revoke) begin
                    blk_d[idx_q] = 1'b1;
                    to_d         = 1'b1;
                end
            end else begin
                hold_d = hold_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            hold_q <= '0;
            blk_q  <= '0;
            to_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            blk_q  <= blk_d;
            to_q   <= to_d;
        end
    end

    assign bus.timeout = to_q;
`else
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Scoreboard bench for ring_rr_arbiter (N=16, HOLD_MAX=8).
module tb_ring_rr_arbiter;

    localparam int N  = 16;
    localparam int HM = 8;

    typedef struct packed {
        logic [15:0] g;
        logic [3:0]  i;
        logic        b;
        logic        t;
    } exp_t;

    logic clk  = 1'b0;
    logic nRST = 1'b0;

    always #5 clk = ~clk;

    ring_rr_arbiter_if #(.N(N), .IW(4)) bus ();

    ring_rr_arbiter #(
        .N        (N),
        .IW       (4),
        .HOLD_MAX (HM)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    int          m_st, m_ptr, m_idx, m_hold;
    logic        m_busy, m_to;
    logic [15:0] m_blk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_ptr  = 0;
        m_idx  = 0;
        m_hold = 0;
        m_busy = 1'b0;
        m_to   = 1'b0;
        m_blk  = '0;
    endtask

    task automatic model_edge(input logic [15:0] r);
        logic [15:0] e;
        logic        rev;
        int          j;
        bit          hit;
        e     = r & ~m_blk;
        m_blk = m_blk & r;
        m_to  = 1'b0;
        if (m_st == 1) begin
            rev = 1'b0;
`ifdef RING_ARB_TIMEOUT_EN
            rev = (m_hold == HM) && r[m_idx];
`endif
            if (!r[m_idx] || rev) begin
                if (rev) begin
                    m_blk[m_idx] = 1'b1;
                    m_to         = 1'b1;
                end
                m_ptr  = (m_idx + 1) % N;
                m_idx  = 0;
                m_busy = 1'b0;
                m_hold = 0;
                m_st   = 2;
            end else begin
                m_hold++;
            end
        end else begin
            hit = 0;
            j   = 0;
            for (int k = 0; k < N; k++) begin
                if (!hit && e[(m_ptr + k) % N]) begin
                    hit = 1;
                    j   = (m_ptr + k) % N;
                end
            end
            if (hit) begin
                m_st   = 1;
                m_idx  = j;
                m_busy = 1'b1;
                m_hold = 1;
            end else begin
                m_st = 0;
            end
        end
    endtask

    // Starts and ends at a falling edge.
    task automatic step(input logic [15:0] r);
        exp_t e;
        exp_t o;
        bus.req = r;
        model_edge(r);
        e.g = m_busy ? 16'(32'd1 << m_idx) : 16'h0;
        e.i = 4'(m_idx);
        e.b = m_busy;
        e.t = m_to;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        o = {bus.grant, bus.grant_idx, bus.busy, bus.timeout};
        e = sbq.pop_front();
        chk("out", 32'(o), 32'(e));
        chk("onehot", 32'($onehot0(bus.grant)), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [15:0] r;
        logic [15:0] prev;
        int          cnt, zeros, c20;
        bit          saw40, after20;

        model_reset();
        bus.req = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_idx", 32'(bus.grant_idx), 32'd0);
        chk("rst_to", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        step(16'hFFFF);
        chk("first", 32'(bus.grant), 32'h0001);

        prev  = bus.grant;
        cnt   = 1;
        zeros = 0;
        for (int k = 0; k < 200 && cnt < 17; k++) begin
            r = 16'hFFFF;
            if (m_busy && m_hold == 3)
                r[m_idx] = 1'b0;
            step(r);
            if (bus.grant == 16'h0) begin
                zeros++;
            end else if (prev == 16'h0) begin
                chk("rot", 32'(bus.grant), 32'd1 << (cnt % 16));
                chk("gap", 32'(zeros), 32'd1);
                cnt++;
                zeros = 0;
            end
            prev = bus.grant;
        end
        chk("rot_cnt", 32'(cnt), 32'd17);

        repeat (3) step(16'h0);
        step(16'h2000);
        repeat (2) step(16'h0);
        step(16'h8001);
        chk("wrap_hi", 32'(bus.grant), 32'h8000);
        step(16'h8001);
        step(16'h0001);
        chk("wrap_rel", 32'(bus.grant), 32'h0000);
        step(16'h0001);
        chk("wrap_lo", 32'(bus.grant), 32'h0001);

        repeat (3) step(16'h0);
        step(16'h0010);
        repeat (2) step(16'h0);
        c20     = 0;
        saw40   = 0;
        after20 = 0;
        for (int k = 0; k < 20; k++) begin
            step(16'hFFFF);
            if (bus.grant == 16'h0020)
                c20++;
            else if (c20 > 0 && bus.grant != 16'h0 && !after20) begin
                after20 = 1;
                saw40   = (bus.grant == 16'h0040);
            end
        end
`ifdef RING_ARB_TIMEOUT_EN
        chk("hold_cnt", 32'(c20), 32'd8);
        chk("hold_next", 32'(saw40), 32'd1);
`else
        chk("hold_cnt", 32'(c20), 32'd20);
        chk("hold_next", 32'(after20), 32'd0);
`endif

        #2;
        nRST = 1'b0;
        #1;
        chk("arst_grant", 32'(bus.grant), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        sbq.delete();
        @(negedge clk);
        nRST = 1'b1;
        step(16'h0048);
        chk("arst_ptr", 32'(bus.grant), 32'h0008);

        repeat (3) step(16'h0);
        chk("lat_pre", 32'(bus.grant), 32'd0);
        step(16'h0010);
        chk("lat_grant", 32'(bus.grant), 32'h0010);
        chk("lat_idx", 32'(bus.grant_idx), 32'd4);

        for (int k = 0; k < 200; k++) begin
            r = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0)
                r = 16'h0;
            if (m_busy && $urandom_range(0, 3) != 0)
                r[m_idx] = 1'b1;
            step(r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
